// File: rtl/gas_pkg.sv
`default_nettype none
// ============================================================================
// Module      : gas_pkg
// Description : Gas codes, signature patterns and transmitter FSM encoding
//               shared by the signature transmitter and the gas detectors.
// Revision    : 1.0 - initial release
// ============================================================================
package gas_pkg;

    localparam logic [1:0] GAS_CH4     = 2'b00;
    localparam logic [1:0] GAS_CO      = 2'b01;
    localparam logic [1:0] GAS_CO2     = 2'b10;
    localparam logic [1:0] GAS_ILLEGAL = 2'b11;

    localparam int SIG_W = 16;

    // Patterns are left-justified so the shift register MSB is the next bit.
    localparam logic [SIG_W-1:0] PAT_CH4 = 16'hB800;  // 10111000
    localparam logic [SIG_W-1:0] PAT_CO  = 16'hA930;  // 101010010011
    localparam logic [SIG_W-1:0] PAT_CO2 = 16'h9200;  // 100100100

    localparam logic [3:0] LEN_CH4 = 4'd8;
    localparam logic [3:0] LEN_CO  = 4'd12;
    localparam logic [3:0] LEN_CO2 = 4'd9;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2
    } tx_state_t;

    function automatic logic [SIG_W-1:0] gas_pattern(input logic [1:0] code);
        case (code)
            GAS_CH4: gas_pattern = PAT_CH4;
            GAS_CO:  gas_pattern = PAT_CO;
            GAS_CO2: gas_pattern = PAT_CO2;
            default: gas_pattern = '0;
        endcase
    endfunction

    function automatic logic [3:0] gas_len(input logic [1:0] code);
        case (code)
            GAS_CH4: gas_len = LEN_CH4;
            GAS_CO:  gas_len = LEN_CO;
            GAS_CO2: gas_len = LEN_CO2;
            default: gas_len = 4'd0;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/gas_bit_timer.sv
`default_nettype none
// ============================================================================
// Module      : gas_bit_timer
// Description : Bit-time divider; flags the last cycle of each bit and
//               registers a strobe for the first cycle of each bit.
// Revision    : 1.0 - initial release
// ============================================================================
module gas_bit_timer #(
    parameter int CLKS_PER_BIT = 1
) (
    input  logic clk,
    input  logic arst,
    input  logic i_clear,
    input  logic i_active_nxt,
    output logic o_tick,
    output logic o_last_nxt,
    output logic o_strobe
);

    localparam int              CW     = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0]   C_LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_nxt;
    logic          r_strobe;

    always_comb begin
        w_cnt_nxt = '0;
        if (!i_clear && (r_cnt != C_LAST)) begin
            w_cnt_nxt = r_cnt + CW'(1);
        end
    end

    assign o_tick     = !i_clear && (r_cnt == C_LAST);
    assign o_last_nxt = (w_cnt_nxt == C_LAST);
    assign o_strobe   = r_strobe;

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            r_cnt    <= '0;
            r_strobe <= 1'b0;
        end else begin
            r_cnt    <= w_cnt_nxt;
            r_strobe <= i_active_nxt && (w_cnt_nxt == '0);
        end
    end

endmodule
`default_nettype wire

// File: rtl/gas_signature_tx.sv
`default_nettype none
// ============================================================================
// Module      : gas_signature_tx
// Description : Serializes a gas bit signature MSB first plus a zero guard
//               gap, optionally repeating the frame.
// Revision    : 1.0 - initial release
// ============================================================================
module gas_signature_tx
    import gas_pkg::*;
#(
    parameter int CLKS_PER_BIT = 1,
    parameter int GAP_BITS     = 4
) (
    input  logic       clk,
    input  logic       arst,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [1:0] req_gas,
    input  logic [3:0] req_repeat,
    output logic       dout,
    output logic       bit_strobe,
    output logic       busy,
    output logic       frame_done,
    output logic       err
);

    localparam int            GW         = $clog2(GAP_BITS + 1);
    localparam logic [GW-1:0] C_GAP_LAST = GW'(GAP_BITS - 1);

    tx_state_t        r_state,  w_state_nxt;
    logic [SIG_W-1:0] r_shift,  w_shift_nxt;
    logic [SIG_W-1:0] r_pat;
    logic [3:0]       r_len;
    logic [3:0]       r_bitcnt, w_bitcnt_nxt;
    logic [GW-1:0]    r_gapcnt, w_gapcnt_nxt;
    logic [3:0]       r_rep,    w_rep_nxt;
    logic             r_dout, r_ready, r_busy, r_fd, r_err;
    logic             w_accept, w_load, w_tick, w_last_nxt;

    gas_bit_timer #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_bit_timer (
        .clk          (clk),
        .arst         (arst),
        .i_clear      (r_state == ST_IDLE),
        .i_active_nxt (w_state_nxt != ST_IDLE),
        .o_tick       (w_tick),
        .o_last_nxt   (w_last_nxt),
        .o_strobe     (bit_strobe)
    );

    assign w_accept = req_valid && r_ready;
    assign w_load   = w_accept && (req_gas != GAS_ILLEGAL);

    always_comb begin
        w_state_nxt  = r_state;
        w_shift_nxt  = r_shift;
        w_bitcnt_nxt = r_bitcnt;
        w_gapcnt_nxt = r_gapcnt;
        w_rep_nxt    = r_rep;
        case (r_state)
            ST_IDLE: begin
                if (w_load) begin
                    w_state_nxt  = ST_SEND;
                    w_shift_nxt  = gas_pattern(req_gas);
                    w_bitcnt_nxt = gas_len(req_gas) - 4'd1;
                    w_rep_nxt    = req_repeat;
                end
            end
            ST_SEND: begin
                if (w_tick) begin
                    w_shift_nxt = {r_shift[SIG_W-2:0], 1'b0};
                    if (r_bitcnt == 4'd0) begin
                        w_state_nxt  = ST_GAP;
                        w_gapcnt_nxt = C_GAP_LAST;
                    end else begin
                        w_bitcnt_nxt = r_bitcnt - 4'd1;
                    end
                end
            end
            ST_GAP: begin
                if (w_tick) begin
                    if (r_gapcnt != '0) begin
                        w_gapcnt_nxt = r_gapcnt - GW'(1);
                    end else if (r_rep != 4'd0) begin
                        // Reload straight into SEND so repeated frames abut.
                        w_state_nxt  = ST_SEND;
                        w_rep_nxt    = r_rep - 4'd1;
                        w_shift_nxt  = r_pat;
                        w_bitcnt_nxt = r_len - 4'd1;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Outputs are registered from next-state values so they align with the state.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            r_state  <= ST_IDLE;
            r_shift  <= '0;
            r_pat    <= '0;
            r_len    <= 4'd0;
            r_bitcnt <= 4'd0;
            r_gapcnt <= '0;
            r_rep    <= 4'd0;
            r_dout   <= 1'b0;
            r_ready  <= 1'b0;
            r_busy   <= 1'b0;
            r_fd     <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_shift  <= w_shift_nxt;
            r_bitcnt <= w_bitcnt_nxt;
            r_gapcnt <= w_gapcnt_nxt;
            r_rep    <= w_rep_nxt;
            if (w_load) begin
                r_pat <= gas_pattern(req_gas);
                r_len <= gas_len(req_gas);
            end
            r_dout  <= (w_state_nxt == ST_SEND) && w_shift_nxt[SIG_W-1];
            r_ready <= (w_state_nxt == ST_IDLE);
            r_busy  <= (w_state_nxt != ST_IDLE);
            r_fd    <= (w_state_nxt == ST_GAP) && (w_gapcnt_nxt == '0) && w_last_nxt;
            r_err   <= w_accept && (req_gas == GAS_ILLEGAL);
        end
    end

    assign dout       = r_dout;
    assign req_ready  = r_ready;
    assign busy       = r_busy;
    assign frame_done = r_fd;
    assign err        = r_err;

endmodule
`default_nettype wire
